piso_serializer: RTL

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 106 ++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with valid/ready load handshake.
// Words are emitted LSB first. The consumer advances through the word with
// shift_en. A new word may be loaded on the edge that consumes the last bit,
// so back-to-back words stream with no gap cycle.
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,         // asynchronous, active-low
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             out_bit,
    output logic             out_valid,
    output logic             done
);

    // The bit counter only needs to index 0..WIDTH-1, with at least one bit.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic             w_last;
    logic             w_load;

    // A load happens whenever the offer meets readiness on a clock edge.
    assign w_load = load_valid & load_ready;
    assign done   = r_done;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and output decode. load_ready is gated by rst so that no
    // load is ever advertised while the block is held in reset.
    always_comb begin
        w_state_next = r_state;
        load_ready   = 1'b0;
        out_valid    = 1'b0;
        out_bit      = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                load_ready = rst;
                if (load_valid && rst) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                out_valid  = 1'b1;
                out_bit    = r_shift[0];
                // Last-bit consumption is combinational on shift_en so the
                // producer can slot the next word into the very same edge.
                w_last     = shift_en && (r_cnt == LAST_IDX);
                load_ready = rst && w_last;
                if (w_last) begin
                    w_state_next = load_valid ? S_SHIFT : S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Shift register and bit counter: reload on accept, otherwise shift
    // right with zero fill on each consumption; hold while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_shift <= load_data;
            r_cnt   <= '0;
        end else if (r_state == S_SHIFT && shift_en) begin
            r_shift <= r_shift >> 1;
            // Wrap to zero on the last bit so the counter never passes WIDTH-1.
            r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
        end
    end

    // done pulses for one cycle after every last-bit consumption.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
        end
    end

endmodule
